// File: rtl/booth_radix4_seq.sv
// booth_radix4_seq: sequential radix-4 Booth multiplier, signed or unsigned N-bit operands, 2N-bit product
module booth_radix4_seq #(
  parameter int N  = 8,
  parameter int CW = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [N-1:0]   data_inM,
  input  logic [N-1:0]   data_inQ,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] ans
);
  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
  localparam logic [CW-1:0] ITERS = CW'(N/2 + 1);
  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N+3:0]   acc_q, acc_d, m_x, term, sum;
  logic [N+1:0]   m_q, m_d, q_q, q_d;
  logic           qm1_q, qm1_d;
  logic [2*N-1:0] ans_q, ans_d;
  logic [2:0]     code;
  // Operands are widened by two bits so unsigned inputs become non-negative signed values
  always_comb begin
    m_x     = {{2{m_q[N+1]}}, m_q};
    code    = {q_q[1:0], qm1_q};
    term    = (code == 3'b001 || code == 3'b010) ? m_x :
              (code == 3'b011)                   ? m_x << 1 :
              (code == 3'b100)                   ? -(m_x << 1) :
              (code == 3'b101 || code == 3'b110) ? -m_x : '0;
    sum     = acc_q + term;
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    m_d     = m_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    ans_d   = ans_q;
    if (state_q == IDLE && start) begin
      m_d     = {{2{signed_mode & data_inM[N-1]}}, data_inM};
      q_d     = {{2{signed_mode & data_inQ[N-1]}}, data_inQ};
      cnt_d   = ITERS;
      acc_d   = '0;
      qm1_d   = 1'b0;
      state_d = ITER;
    end else if (state_q == ITER) begin
      acc_d = {{2{sum[N+3]}}, sum[N+3:2]};
      q_d   = {sum[1:0], q_q[N+1:2]};
      qm1_d = q_q[1];
      cnt_d = cnt_q - CW'(1);
      // After the last shift {acc,q} holds the full product; its low 2N bits are the answer
      if (cnt_q == CW'(1)) begin
        state_d = DONE;
        ans_d   = {acc_d[N-3:0], q_d};
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      m_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      ans_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      m_q     <= m_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      ans_q   <= ans_d;
    end
  end
  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign ans  = ans_q;
endmodule

// File: tb/tb_booth_radix4_seq.sv
// tb_booth_radix4_seq: random and directed checks of booth_radix4_seq at N=8 and N=16 against an arithmetic model
module tb_booth_radix4_seq;
  logic        clk = 1'b0;
  logic        reset, st8, st16, smode;
  logic [15:0] dm, dq;
  logic        busy8, done8, busy16, done16;
  logic [15:0] ans8;
  logic [31:0] ans16;
  int          total = 0;
  int          bad   = 0;

  booth_radix4_seq #(.N(8), .CW(4)) dut8 (
    .clk(clk), .reset(reset), .start(st8), .signed_mode(smode),
    .data_inM(dm[7:0]), .data_inQ(dq[7:0]), .busy(busy8), .done(done8), .ans(ans8)
  );
  booth_radix4_seq #(.N(16), .CW(5)) dut16 (
    .clk(clk), .reset(reset), .start(st16), .signed_mode(smode),
    .data_inM(dm), .data_inQ(dq), .busy(busy16), .done(done16), .ans(ans16)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_prod(input bit w, input logic [15:0] m, input logic [15:0] q, input bit sm);
    longint a, b, p;
    if (w) begin
      a = sm ? longint'($signed(m)) : longint'(m);
      b = sm ? longint'($signed(q)) : longint'(q);
    end else begin
      a = sm ? longint'($signed(m[7:0])) : longint'(m[7:0]);
      b = sm ? longint'($signed(q[7:0])) : longint'(q[7:0]);
    end
    p = a * b;
    return w ? p[31:0] : {16'h0, p[15:0]};
  endfunction

  // Called at a negedge with the selected DUT idle; returns at the first IDLE negedge after done
  task automatic mul(input bit w, input logic [15:0] m, input logic [15:0] q, input bit sm, input bit poke);
    logic [31:0] exp;
    int n;
    exp = ref_prod(w, m, q, sm);
    dm = m; dq = q; smode = sm;
    if (w) st16 = 1'b1; else st8 = 1'b1;
    @(negedge clk);
    st8 = 1'b0; st16 = 1'b0;
    dm = 16'($urandom); dq = 16'($urandom); smode = 1'($urandom);
    chk("busy_after_accept", w ? busy16 : busy8, 1);
    n = 0;
    while (!(w ? done16 : done8) && n < 40) begin
      if (poke && n == 2) begin
        dm = ~m; dq = q + 16'd1; smode = ~sm;
        if (w) st16 = 1'b1; else st8 = 1'b1;
      end
      @(negedge clk);
      n++;
    end
    chk("latency_edges", n + 1, w ? 10 : 6);
    chk("ans_at_done", w ? ans16 : {16'h0, ans8}, exp);
    chk("busy_at_done", w ? busy16 : busy8, 1);
    @(negedge clk);
    st8 = 1'b0; st16 = 1'b0;
    chk("done_one_cycle", w ? done16 : done8, 0);
    chk("busy_back_idle", w ? busy16 : busy8, 0);
    chk("ans_held", w ? ans16 : {16'h0, ans8}, exp);
    if (poke) begin
      @(negedge clk);
      chk("no_restart", w ? busy16 : busy8, 0);
      chk("ans_still_held", w ? ans16 : {16'h0, ans8}, exp);
    end
  endtask

  initial begin
    int pulses;
    reset = 1'b0; st8 = 1'b0; st16 = 1'b0; smode = 1'b0; dm = '0; dq = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy8", busy8, 0);
    chk("rst_done8", done8, 0);
    chk("rst_ans8", ans8, 0);
    chk("rst_busy16", busy16, 0);
    chk("rst_ans16", ans16, 0);
    st8 = 1'b1;
    @(negedge clk);
    chk("start_ignored_in_reset", busy8, 0);
    reset = 1'b1;
    mul(0, 16'h00FD, 16'h0007, 1, 0);
    mul(0, 16'h00FF, 16'h00FF, 0, 0);
    mul(0, 16'h00FF, 16'h00FF, 1, 0);
    mul(0, 16'h0080, 16'h0080, 1, 0);
    mul(0, 16'h0080, 16'h007F, 1, 0);
    mul(0, 16'h0023, 16'h0045, 1, 1);
    mul(1, 16'h8000, 16'h8000, 1, 0);
    mul(1, 16'hFFFF, 16'hFFFF, 0, 0);
    // Abandon an operation with a one-edge reset in its third ITER cycle
    dm = 16'h0012; dq = 16'h0034; smode = 1'b0; st8 = 1'b1;
    @(negedge clk);
    st8 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("midrst_busy", busy8, 0);
    chk("midrst_done", done8, 0);
    chk("midrst_ans", ans8, 0);
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      pulses += int'(done8);
    end
    chk("midrst_no_done", pulses, 0);
    mul(0, 16'd5, 16'd6, 0, 0);
    chk("five_times_six", ans8, 16'h001E);
    for (int i = 0; i < 60; i++) begin
      mul(0, 16'($urandom), 16'($urandom), 1'($urandom), ($urandom % 5) == 0);
      if ($urandom % 4 == 0) @(negedge clk);
    end
    for (int i = 0; i < 60; i++) begin
      mul(1, 16'($urandom), 16'($urandom), 1'($urandom), ($urandom % 5) == 0);
      if ($urandom % 4 == 0) @(negedge clk);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
